ysyx_24100012_ifu: RTL and testbench
====================================

# ysyx_24100012_ifu

Instruction fetch unit for the NPC core. It owns the PC, issues word reads to instruction memory over a valid/ready request channel, and captures the returned word. It then presents `instruction` and `inst_pc` to the decode stage with a valid/ready handshake. Redirects from execute (branches, jal/jalr) and a halt from ebreak steer or stop fetching.

## Interface
- `DATA_WIDTH`, 32, width of PC, address and instruction
- `RESET_PC`, 32'h8000_0000, PC loaded on reset
- `clk` input 1: single clock, all state on rising edge
- `rst` input 1: synchronous, active-high reset
- `imem_req_valid` output 1: fetch request valid
- `imem_req_ready` input 1: memory accepts request
- `imem_req_addr` output DATA_WIDTH: word address, equals current PC
- `imem_rsp_valid` input 1: read data valid (one pulse per accepted request)
- `imem_rsp_data` input DATA_WIDTH: fetched instruction word
- `imem_rsp_err` input 1: access error, qualified by `imem_rsp_valid`
- `inst_valid` output 1: `instruction`/`inst_pc` valid to decode
- `inst_ready` input 1: decode accepts instruction
- `instruction` output DATA_WIDTH: fetched word, registered
- `inst_pc` output DATA_WIDTH: PC of `instruction`
- `redirect_valid` input 1: single-cycle redirect pulse from execute
- `redirect_pc` input DATA_WIDTH: redirect target
- `halt` input 1: level; blocks new requests while high
- `fetch_fault` output 1: sticky fault flag, cleared only by `rst`

## Operation
- FSM states: REQ, WAIT, HOLD, DROP.
- `imem_req_valid = (state==REQ) & ~halt & ~fetch_fault`.
- `imem_req_addr = pc`.
- REQ → WAIT on request handshake.
- WAIT: on `imem_rsp_valid`, register data into `instruction` and pc into `inst_pc`, then go to HOLD.
- HOLD: `inst_valid`=1. On `inst_ready`, set pc ← pc+4 (modulo 2^DATA_WIDTH, wraps silently) and go to REQ.
- `imem_rsp_err` in WAIT: set `fetch_fault` and go to REQ. No `inst_valid` is raised and nothing further is issued.
- Redirect has priority over normal next-PC in every state:
  - REQ without handshake: pc ← redirect_pc, stay in REQ.
  - REQ with handshake in the same cycle: the request goes out with the old pc. Then pc ← redirect_pc and go to DROP.
  - WAIT with `imem_rsp_valid` in the same cycle: discard the response, pc ← redirect_pc, go to REQ.
  - WAIT without a response: pc ← redirect_pc, go to DROP.
  - HOLD: deassert `inst_valid` next cycle, pc ← redirect_pc, go to REQ. If `inst_ready` is high in the same cycle, the handshake still counts as completed, but the next pc is redirect_pc, not pc+4.
- DROP: discard the next response (including any error), then go to REQ.
- `halt` only gates new requests. Outstanding responses complete, and HOLD still delivers.

## Timing
- Reset values: pc=RESET_PC, state=REQ, `inst_valid`=0, `instruction`=0, `inst_pc`=0, `fetch_fault`=0.
- `imem_req_valid`=1 in the first cycle after `rst` falls, provided `halt`=0.
- Zero-wait memory (response in the cycle after the request handshake): `inst_valid` rises 2 cycles after the request handshake. Best-case throughput is 1 instruction per 3 cycles.
- `instruction`/`inst_pc` are stable while `inst_valid`=1 and `inst_ready`=0.
- `rst` mid-operation returns to reset values. A response arriving after `rst` falls, for a pre-reset request, is ignored in REQ. Memory must flush on the same `rst`.
- `imem_rsp_valid` outside WAIT/DROP is ignored.

## Configuration
- `YSYX_24100012_IFU_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 sets `fetch_fault` in the next cycle.
  - pc still loads the target, but no further requests are issued.
- Macro undefined: `redirect_pc[1:0]` is forced to 2'b00 when loaded, and no fault is raised.

## Structure
- Shared package/header: FSM state encodings, `RESET_PC` default, instruction width constant.
- One sub-module, `ysyx_24100012_ifu_pc`: PC register with next-PC select (hold / +4 / redirect / reset) and the alignment handling.

## Test plan
- Reset, zero-wait memory returning 32'h00000013:
  - first request addr=32'h8000_0000;
  - `inst_valid` appears 2 cycles after the handshake with `inst_pc`=32'h8000_0000;
  - next request addr=32'h8000_0004.
- Back-pressure:
  - `inst_ready`=0 for 5 cycles keeps `inst_valid`=1 with `instruction` unchanged;
  - no new request is issued until the `inst_ready` handshake.
- Redirect to 32'h8000_0100 in WAIT with the response 3 cycles later:
  - the stale response is dropped (`inst_valid` stays 0);
  - the next request addr=32'h8000_0100.
- Redirect in HOLD together with `inst_ready`=1: next request addr = redirect_pc, not pc+4.
- `imem_rsp_err`=1 → `fetch_fault`=1 permanently, `imem_req_valid`=0 until `rst`.
- With `YSYX_24100012_IFU_ALIGN_CHECK_EN`, redirect to 32'h8000_0102 → `fetch_fault`=1. Without the macro → next request addr=32'h8000_0100.

Source files
------------

// File: rtl/ysyx_24100012_ifu_pkg.sv
// ysyx_24100012_ifu_pkg
//   Shared definitions for the NPC instruction fetch unit:
//   FSM state encoding, next-PC select encoding, default data width,
//   instruction width and the default reset PC.
package ysyx_24100012_ifu_pkg;

    localparam int unsigned IFU_DATA_WIDTH = 32;
    localparam int unsigned INST_WIDTH     = 32;
    localparam logic [31:0] IFU_RESET_PC   = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,  // request may be issued
        ST_WAIT = 2'd1,  // request accepted, waiting for the response
        ST_HOLD = 2'd2,  // instruction presented to decode
        ST_DROP = 2'd3   // next response is stale and is discarded
    } ifu_state_t;

    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_INC   = 2'd1,
        PC_REDIR = 2'd2
    } pc_sel_t;

endpackage

// File: rtl/ysyx_24100012_ifu_if.sv
// ysyx_24100012_ifu_if
//   Bundle of every fetch-unit signal except clk/rst.
//   master : the fetch unit side
//   slave  : the environment side (instruction memory, decode, execute)
//   Signals:
//     imem_req_valid/ready/addr       fetch request channel
//     imem_rsp_valid/data/err         fetch response
//     inst_valid/ready, instruction,
//     inst_pc                         instruction handed to decode
//     redirect_valid/pc               redirect pulse from execute
//     halt                            level, blocks new requests
//     fetch_fault                     sticky fault flag
interface ysyx_24100012_ifu_if
    import ysyx_24100012_ifu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = IFU_DATA_WIDTH
);

    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [DATA_WIDTH-1:0] imem_req_addr;
    logic                  imem_rsp_valid;
    logic [DATA_WIDTH-1:0] imem_rsp_data;
    logic                  imem_rsp_err;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [DATA_WIDTH-1:0] instruction;
    logic [DATA_WIDTH-1:0] inst_pc;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  halt;
    logic                  fetch_fault;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output inst_valid, instruction, inst_pc,
        input  inst_ready,
        input  redirect_valid, redirect_pc, halt,
        output fetch_fault
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  inst_valid, instruction, inst_pc,
        output inst_ready,
        output redirect_valid, redirect_pc, halt,
        input  fetch_fault
    );

endinterface

// File: rtl/ysyx_24100012_ifu_pc.sv
// ysyx_24100012_ifu_pc
//   Program counter register with next-PC select (hold / +4 / redirect,
//   synchronous reset to RESET_PC) and redirect alignment handling.
//   Optional macro: YSYX_24100012_IFU_ALIGN_CHECK_EN
//     defined   : redirect target loaded as-is, misaligned target flagged
//     undefined : low two target bits forced to zero, never flagged
//   Ports:
//     clk, rst         clock, synchronous active-high reset
//     i_sel            next-PC select
//     i_redirect_pc    redirect target
//     o_pc             current PC
//     o_misalign       redirect this cycle has a misaligned target
module ysyx_24100012_ifu_pc
    import ysyx_24100012_ifu_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = IFU_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(IFU_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  pc_sel_t               i_sel,
    input  logic [DATA_WIDTH-1:0] i_redirect_pc,
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic                  o_misalign
);

    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~(DATA_WIDTH'(3));

    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] w_target;
    logic [DATA_WIDTH-1:0] w_pc_next;

`ifdef YSYX_24100012_IFU_ALIGN_CHECK_EN
    assign w_target   = i_redirect_pc;
    assign o_misalign = (i_sel == PC_REDIR) && ((i_redirect_pc & ~ALIGN_MASK) != '0);
`else
    assign w_target   = i_redirect_pc & ALIGN_MASK;
    assign o_misalign = 1'b0;
`endif

    always_comb begin
        w_pc_next = r_pc;
        case (i_sel)
            PC_INC:   w_pc_next = r_pc + DATA_WIDTH'(4);  // wraps silently
            PC_REDIR: w_pc_next = w_target;
            default:  w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_pc <= RESET_PC;
        else     r_pc <= w_pc_next;
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/ysyx_24100012_ifu.sv
// ysyx_24100012_ifu
//   Instruction fetch unit: owns the PC, issues word reads over a
//   valid/ready request channel, registers the returned word and hands
//   it to decode with a valid/ready handshake. Execute redirects steer
//   the PC; halt blocks new requests; an access error latches a sticky
//   fault that stops fetching until reset.
//   Optional macro: YSYX_24100012_IFU_ALIGN_CHECK_EN (misaligned redirect
//   target raises fetch_fault instead of being silently aligned).
//   Ports:
//     clk, rst   clock, synchronous active-high reset
//     bus        ysyx_24100012_ifu_if.master (all fetch/decode/redirect signals)
module ysyx_24100012_ifu
    import ysyx_24100012_ifu_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = IFU_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(IFU_RESET_PC)
) (
    input  logic                clk,
    input  logic                rst,
    ysyx_24100012_ifu_if.master bus
);

    ifu_state_t            r_state;
    logic [DATA_WIDTH-1:0] r_instruction;
    logic [DATA_WIDTH-1:0] r_inst_pc;
    logic                  r_fault;

    ifu_state_t            w_state_next;
    pc_sel_t               w_pc_sel;
    logic [DATA_WIDTH-1:0] w_pc;
    logic                  w_misalign;
    logic                  w_req_fire;
    logic                  w_capture;
    logic                  w_err_set;

    ysyx_24100012_ifu_pc #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc (
        .clk           (clk),
        .rst           (rst),
        .i_sel         (w_pc_sel),
        .i_redirect_pc (bus.redirect_pc),
        .o_pc          (w_pc),
        .o_misalign    (w_misalign)
    );

    assign bus.imem_req_valid = (r_state == ST_REQ) & ~bus.halt & ~r_fault;
    assign bus.imem_req_addr  = w_pc;
    assign w_req_fire         = bus.imem_req_valid & bus.imem_req_ready;

    always_comb begin
        w_state_next = r_state;
        w_pc_sel     = PC_HOLD;
        w_capture    = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            ST_REQ: begin
                if (bus.redirect_valid) begin
                    // A request fired this cycle carries the old PC; its
                    // response must be thrown away.
                    w_pc_sel = PC_REDIR;
                    if (w_req_fire) w_state_next = ST_DROP;
                end else if (w_req_fire) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.redirect_valid) begin
                    w_pc_sel     = PC_REDIR;
                    w_state_next = bus.imem_rsp_valid ? ST_REQ : ST_DROP;
                end else if (bus.imem_rsp_valid) begin
                    if (bus.imem_rsp_err) begin
                        w_err_set    = 1'b1;
                        w_state_next = ST_REQ;
                    end else begin
                        w_capture    = 1'b1;
                        w_state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // Redirect wins over +4 even when decode accepts this cycle.
                if (bus.redirect_valid) begin
                    w_pc_sel     = PC_REDIR;
                    w_state_next = ST_REQ;
                end else if (bus.inst_ready) begin
                    w_pc_sel     = PC_INC;
                    w_state_next = ST_REQ;
                end
            end
            ST_DROP: begin
                if (bus.redirect_valid) w_pc_sel = PC_REDIR;
                if (bus.imem_rsp_valid) w_state_next = ST_REQ;
            end
            default: w_state_next = ST_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_REQ;
            r_instruction <= '0;
            r_inst_pc     <= '0;
            r_fault       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_fault <= r_fault | w_err_set | w_misalign;
            if (w_capture) begin
                r_instruction <= bus.imem_rsp_data;
                r_inst_pc     <= w_pc;
            end
        end
    end

    assign bus.inst_valid  = (r_state == ST_HOLD);
    assign bus.instruction = r_instruction;
    assign bus.inst_pc     = r_inst_pc;
    assign bus.fetch_fault = r_fault;

endmodule

// File: tb/tb_ysyx_24100012_ifu.sv
// tb_ysyx_24100012_ifu
//   Directed bench for ysyx_24100012_ifu with a single-outstanding memory
//   model whose read data is {addr[15:0], 16'h0013}. Expected request
//   addresses and expected (inst_pc, instruction) pairs are queued by the
//   stimulus and checked by independent monitors.
module tb_ysyx_24100012_ifu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_24100012_ifu_if #(.DATA_WIDTH(32)) bus ();

    ysyx_24100012_ifu #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h8000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int req_cnt  = 0;
    int last_fire_cyc = 0;
    int mem_lat  = 1;
    logic mem_err = 1'b0;

    logic [31:0] exp_req_q[$];
    logic [63:0] exp_inst_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    // Memory model and request monitor
    initial begin : mem_model
        bit          pend;
        int          cnt;
        logic [31:0] paddr;
        pend = 0; cnt = 0; paddr = '0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_rsp_err   = 1'b0;
        forever begin
            @(negedge clk); #1;
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_err   = 1'b0;
            if (rst) begin
                pend = 0;
            end else begin
                if (pend) begin
                    if (cnt == 0) begin
                        bus.imem_rsp_valid = 1'b1;
                        bus.imem_rsp_data  = {paddr[15:0], 16'h0013};
                        bus.imem_rsp_err   = mem_err;
                        pend = 0;
                    end else begin
                        cnt--;
                    end
                end
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    req_cnt++;
                    last_fire_cyc = cyc;
                    pend  = 1;
                    cnt   = mem_lat - 1;
                    paddr = bus.imem_req_addr;
                    if (exp_req_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL req_unexpected: got request addr %h, required no request", bus.imem_req_addr);
                    end else begin
                        check("req_addr", bus.imem_req_addr, exp_req_q.pop_front());
                    end
                end
            end
        end
    end

    // Decode-side monitor
    initial begin : inst_monitor
        logic [63:0] e;
        forever begin
            @(negedge clk); #1;
            if (!rst && bus.inst_valid && bus.inst_ready) begin
                if (exp_inst_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL inst_unexpected: got pc %h instr %h, required none", bus.inst_pc, bus.instruction);
                end else begin
                    e = exp_inst_q.pop_front();
                    check("inst_pc", bus.inst_pc, e[63:32]);
                    check("instruction", bus.instruction, e[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_req(input int target, input string name);
        int b = 0;
        while (req_cnt < target && b < 100) begin step(); b++; end
        if (req_cnt < target) timeout(name);
    endtask

    task automatic wait_inst_valid(input string name);
        int b = 0;
        while (!bus.inst_valid && b < 100) begin step(); b++; end
        if (!bus.inst_valid) timeout(name);
    endtask

    task automatic wait_drained(input string name);
        int b = 0;
        while ((exp_inst_q.size() != 0 || bus.inst_valid) && b < 100) begin step(); b++; end
        if (exp_inst_q.size() != 0) timeout(name);
        step();
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        step();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin : stimulus
        int r0;
        logic [31:0] err_addr;
        bus.halt           = 1'b0;
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        // Reset values
        repeat (3) step();
        check("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("rst_instruction", bus.instruction, 32'h0);
        check("rst_inst_pc", bus.inst_pc, 32'h0);
        check("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);
        check("rst_req_addr", bus.imem_req_addr, 32'h8000_0000);

        // Zero-wait fetch of two words
        exp_req_q.push_back(32'h8000_0000);
        exp_req_q.push_back(32'h8000_0004);
        exp_inst_q.push_back({32'h8000_0000, 32'h0000_0013});
        exp_inst_q.push_back({32'h8000_0004, 32'h0004_0013});
        r0 = req_cnt;
        rst = 1'b0;
        check("first_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        wait_inst_valid("s1_inst_valid");
        check("latency", 32'(cyc - last_fire_cyc), 32'd2);
        wait_req(r0 + 2, "s1_req");
        bus.halt = 1'b1;
        wait_drained("s1_drain");

        // Back-pressure
        exp_req_q.push_back(32'h8000_0008);
        exp_inst_q.push_back({32'h8000_0008, 32'h0008_0013});
        bus.inst_ready = 1'b0;
        bus.halt = 1'b0;
        wait_inst_valid("s2_inst_valid");
        for (int i = 0; i < 5; i++) begin
            check("bp_inst_valid", {31'd0, bus.inst_valid}, 32'd1);
            check("bp_instruction", bus.instruction, 32'h0008_0013);
            check("bp_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
            step();
        end
        bus.halt = 1'b1;
        bus.inst_ready = 1'b1;
        wait_drained("s2_drain");

        // Redirect in WAIT, stale response arrives later
        mem_lat = 4;
        exp_req_q.push_back(32'h8000_000C);
        exp_req_q.push_back(32'h8000_0100);
        exp_inst_q.push_back({32'h8000_0100, 32'h0100_0013});
        r0 = req_cnt;
        bus.halt = 1'b0;
        wait_req(r0 + 1, "s3_req0");
        pulse_redirect(32'h8000_0100);
        wait_req(r0 + 2, "s3_req1");
        bus.halt = 1'b1;
        wait_drained("s3_drain");
        mem_lat = 1;

        // Redirect in HOLD together with inst_ready
        exp_req_q.push_back(32'h8000_0104);
        exp_req_q.push_back(32'h8000_0200);
        exp_inst_q.push_back({32'h8000_0104, 32'h0104_0013});
        exp_inst_q.push_back({32'h8000_0200, 32'h0200_0013});
        r0 = req_cnt;
        bus.halt = 1'b0;
        wait_inst_valid("s4_inst_valid");
        pulse_redirect(32'h8000_0200);
        wait_req(r0 + 2, "s4_req");
        bus.halt = 1'b1;
        wait_drained("s4_drain");

        // PC wrap past the top of the address space
        pulse_redirect(32'hFFFF_FFFC);
        exp_req_q.push_back(32'hFFFF_FFFC);
        exp_req_q.push_back(32'h0000_0000);
        exp_inst_q.push_back({32'hFFFF_FFFC, 32'hFFFC_0013});
        exp_inst_q.push_back({32'h0000_0000, 32'h0000_0013});
        r0 = req_cnt;
        bus.halt = 1'b0;
        wait_req(r0 + 2, "s5_req");
        bus.halt = 1'b1;
        wait_drained("s5_drain");

        // Misaligned redirect
        pulse_redirect(32'h8000_0102);
`ifdef YSYX_24100012_IFU_ALIGN_CHECK_EN
        check("align_fault", {31'd0, bus.fetch_fault}, 32'd1);
        bus.halt = 1'b0;
        repeat (3) begin
            step();
            check("align_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
        end
        bus.halt = 1'b1;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        err_addr = 32'h8000_0000;
`else
        check("align_no_fault", {31'd0, bus.fetch_fault}, 32'd0);
        exp_req_q.push_back(32'h8000_0100);
        exp_inst_q.push_back({32'h8000_0100, 32'h0100_0013});
        r0 = req_cnt;
        bus.halt = 1'b0;
        wait_req(r0 + 1, "s6_req");
        bus.halt = 1'b1;
        wait_drained("s6_drain");
        err_addr = 32'h8000_0104;
`endif

        // Access error: sticky fault, no further requests or deliveries
        mem_err = 1'b1;
        exp_req_q.push_back(err_addr);
        r0 = req_cnt;
        bus.halt = 1'b0;
        wait_req(r0 + 1, "s7_req");
        step();
        for (int i = 0; i < 5; i++) begin
            check("err_fault", {31'd0, bus.fetch_fault}, 32'd1);
            check("err_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
            check("err_no_inst", {31'd0, bus.inst_valid}, 32'd0);
            step();
        end
        mem_err = 1'b0;

        // Reset clears the fault; then reset in the middle of a fetch
        rst = 1'b1;
        repeat (2) step();
        check("rst2_fault", {31'd0, bus.fetch_fault}, 32'd0);
        check("rst2_req_addr", bus.imem_req_addr, 32'h8000_0000);
        mem_lat = 3;
        exp_req_q.push_back(32'h8000_0000);
        r0 = req_cnt;
        rst = 1'b0;
        wait_req(r0 + 1, "s8_req");
        rst = 1'b1;
        bus.halt = 1'b1;
        repeat (2) step();
        check("rst3_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("rst3_instruction", bus.instruction, 32'h0);
        check("rst3_inst_pc", bus.inst_pc, 32'h0);
        check("rst3_req_addr", bus.imem_req_addr, 32'h8000_0000);
        rst = 1'b0;
        repeat (5) step();
        check("rst3_no_inst", {31'd0, bus.inst_valid}, 32'd0);
        check("rst3_halt_no_req", {31'd0, bus.imem_req_valid}, 32'd0);

        check("req_queue_empty", exp_req_q.size(), 32'd0);
        check("inst_queue_empty", exp_inst_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
